// File: rtl/mix_pipe_pkg.sv
// Shared types and helpers for the mix_pipe benchmark netlist.
// Session FSM states and MISR feedback tap generation.
package mix_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Taps on bits 0..2, trimmed to the register width.
  function automatic logic [63:0] misr_taps(input int w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return 64'h7 & m;
  endfunction

endpackage

// File: rtl/mix_pipe_core.sv
// Combinational LANES-wide six-NAND mixing network.
// Each lane is independent; no state.
module mix_core
  import mix_pipe_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic [LANES-1:0] c,
  input  logic [LANES-1:0] d,
  input  logic [LANES-1:0] e,
  output logic [LANES-1:0] o16,
  output logic [LANES-1:0] o17
);

  logic [LANES-1:0] n8;
  logic [LANES-1:0] n9;
  logic [LANES-1:0] n12;
  logic [LANES-1:0] n15;

  assign n8  = ~(a & c);
  assign n9  = ~(c & d);
  assign n12 = ~(b & n9);
  assign n15 = ~(n9 & e);
  assign o16 = ~(n8 & n12);
  assign o17 = ~(n12 & n15);

endmodule

// File: rtl/mix_pipe.sv
// Session-framed valid/ready pipeline around the NAND mixing network.
// Optional output signature register: MIX_PIPE_MISR_EN.
module mix_pipe
  import mix_pipe_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES-1:0]   a,
  input  logic [LANES-1:0]   b,
  input  logic [LANES-1:0]   c,
  input  logic [LANES-1:0]   d,
  input  logic [LANES-1:0]   e,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES-1:0]   o16,
  output logic [LANES-1:0]   o17,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   count,
  output logic [2*LANES-1:0] sig
);

  localparam int W = 2 * LANES;

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] count_q;
  logic [DEPTH-1:0] vld;
  logic [W-1:0]     dat [DEPTH];
  logic [LANES-1:0] m16;
  logic [LANES-1:0] m17;
  logic             stall;
  logic             in_fire;
  logic             out_fire;
  logic             start_ok;

  mix_core #(.LANES(LANES)) u_core (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .e   (e),
    .o16 (m16),
    .o17 (m17)
  );

  assign out_valid  = vld[DEPTH-1];
  assign {o17, o16} = dat[DEPTH-1];
  assign stall      = out_valid & ~out_ready;
  assign in_ready   = (state == RUN) && (issued < len_q) && !stall;
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign start_ok   = (state == IDLE) && start;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign count      = count_q;

  // Session state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Session transitions; last in/out handshakes end RUN/DRAIN.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        if (in_fire && (CNT_W'(issued + 1'b1) == len_q))
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (out_fire && (CNT_W'(count_q + 1'b1) == len_q))
          state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Session length latch and issue/retire counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued  <= '0;
      count_q <= '0;
      len_q   <= '0;
    end else if (start_ok) begin
      issued  <= '0;
      count_q <= '0;
      len_q   <= len;
    end else begin
      if (in_fire)  issued  <= issued + 1'b1;
      if (out_fire) count_q <= count_q + 1'b1;
    end
  end

  // Lock-step pipeline; a stall freezes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
    end else if (!stall) begin
      vld[0] <= in_fire;
      dat[0] <= {m17, m16};
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

`ifdef MIX_PIPE_MISR_EN
  localparam logic [63:0] TAPS_F = misr_taps(W);
  localparam logic [W-1:0] TAPS  = TAPS_F[W-1:0];

  logic [W-1:0] sig_q;

  // Signature folds in each retired output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sig_q <= '0;
    else if (start_ok)
      sig_q <= '0;
    else if (out_fire)
      sig_q <= ({sig_q[W-2:0], 1'b0}
               ^ (sig_q[W-1] ? TAPS : '0))
               ^ {o17, o16};
  end

  assign sig = sig_q;
`else
  assign sig = '0;
`endif

endmodule

// File: tb/tb_mix_pipe.sv
// Directed self-checking bench for mix_pipe.
// Two instances: LANES=4 and LANES=1, sharing control.
module tb_mix_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = 8'd0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] a = '0, b = '0, c = '0, d = '0, e = '0;

  logic       in_ready, out_valid, busy, done;
  logic [3:0] o16, o17;
  logic [7:0] count;
  logic [7:0] sig;

  logic       in_ready1, out_valid1, busy1, done1;
  logic [0:0] o16_1, o17_1;
  logic [7:0] count1;
  logic [1:0] sig1;

  mix_pipe #(.LANES(4), .DEPTH(2), .CNT_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .out_valid(out_valid), .out_ready(out_ready),
    .o16(o16), .o17(o17), .busy(busy), .done(done),
    .count(count), .sig(sig)
  );

  mix_pipe #(.LANES(1), .DEPTH(2), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready1),
    .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]), .e(e[0]),
    .out_valid(out_valid1), .out_ready(out_ready),
    .o16(o16_1), .o17(o17_1), .busy(busy1), .done(done1),
    .count(count1), .sig(sig1)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0] va [3] = '{4'hF, 4'hF, 4'h0};
  logic [3:0] vb [3] = '{4'hF, 4'h0, 4'h0};
  logic [3:0] vc [3] = '{4'hF, 4'hF, 4'h0};
  logic [3:0] vd [3] = '{4'hF, 4'h0, 4'h0};
  logic [3:0] ve [3] = '{4'hF, 4'hF, 4'h0};
  logic [3:0] x16 [3] = '{4'hF, 4'hF, 4'h0};
  logic [3:0] x17 [3] = '{4'h0, 4'hF, 4'h0};
  logic [1:0] xsig [3] = '{2'b01, 2'b01, 2'b10};
  logic [1:0] x1 [3] = '{2'b01, 2'b11, 2'b00};

  int         hs_cyc [16];
  int         out_cyc [16];
  logic [3:0] r16 [16];
  logic [3:0] r17 [16];
  logic [1:0] r1 [16];
  logic [1:0] rsig [16];
  int n_hs, n_out, n_sig, done_cnt, done_cyc;
  int stall_bad, ir_seen, tmo;

  // Stimulus driver: one session, records what it observes.
  task automatic run_sess(input int n, input int st_from,
                          input int st_len, input int rs_at);
    logic       fired;
    logic [3:0] h16, h17;
    int         vi;
    int         cyc;
    n_hs = 0; n_out = 0; n_sig = 0; done_cnt = 0;
    done_cyc = -10; stall_bad = 0; ir_seen = 0; tmo = 0;
    fired = 1'b0; vi = 0; h16 = '0; h17 = '0;
    @(negedge clk);
    start = 1'b1; len = 8'(n); in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      cyc = k + 1;
      start = (cyc == rs_at);
      if (start) len = 8'd7;
      out_ready = !(cyc >= st_from && cyc < st_from + st_len);
      if (vi < n) begin
        in_valid = 1'b1;
        a = va[vi % 3]; b = vb[vi % 3]; c = vc[vi % 3];
        d = vd[vi % 3]; e = ve[vi % 3];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (fired && n_sig < 16) begin
        rsig[n_sig] = sig1;
        n_sig++;
      end
      fired = out_valid && out_ready;
      if (fired && n_out < 16) begin
        r16[n_out] = o16; r17[n_out] = o17;
        r1[n_out] = {o17_1, o16_1};
        out_cyc[n_out] = cyc;
        n_out++;
      end
      if (in_ready) ir_seen++;
      if (in_valid && in_ready && vi < 16) begin
        hs_cyc[vi] = cyc;
        vi++;
      end
      if (!out_ready) begin
        if (!out_valid || in_ready) stall_bad++;
        if (cyc == st_from) begin
          h16 = o16; h17 = o17;
        end else if (o16 !== h16 || o17 !== h17) begin
          stall_bad++;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt > 0 && cyc == done_cyc + 2) break;
    end
    if (done_cnt == 0) tmo = 1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_hs = vi;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_chk++;
    if ({in_ready, out_valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000",
               {in_ready, out_valid, busy, done});
    end
    n_chk++;
    if ({o16, o17, count, sig} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 000000",
               {o16, o17, count, sig});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mixing();
    run_sess(3, 0, 0, -1);
    n_chk++;
    if (tmo != 0 || n_out != 3) begin
      n_fail++;
      $display("FAIL mix_outs: got %0d outputs tmo %0d expected 3 tmo 0",
               n_out, tmo);
    end
    for (int k = 0; k < 3 && k < n_out; k++) begin
      n_chk++;
      if (r16[k] !== x16[k] || r17[k] !== x17[k]) begin
        n_fail++;
        $display("FAIL mix_vec%0d: got o16=%h o17=%h expected o16=%h o17=%h",
                 k, r16[k], r17[k], x16[k], x17[k]);
      end
      n_chk++;
      if (out_cyc[k] - hs_cyc[k] != 2) begin
        n_fail++;
        $display("FAIL mix_lat%0d: got %0d expected 2",
                 k, out_cyc[k] - hs_cyc[k]);
      end
    end
    n_chk++;
    if (done_cnt != 1 || done_cyc != 6) begin
      n_fail++;
      $display("FAIL mix_done: got cnt %0d cyc %0d expected cnt 1 cyc 6",
               done_cnt, done_cyc);
    end
    n_chk++;
    if (count !== 8'd3 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mix_count: got count %0d busy %b expected 3 busy 0",
               count, busy);
    end
  endtask

  task automatic test_signature();
    logic [1:0] exp_s;
    run_sess(3, 0, 0, -1);
    n_chk++;
    if (n_sig != 3 || tmo != 0) begin
      n_fail++;
      $display("FAIL sig_n: got %0d tmo %0d expected 3 tmo 0", n_sig, tmo);
    end
    for (int k = 0; k < 3 && k < n_sig; k++) begin
`ifdef MIX_PIPE_MISR_EN
      exp_s = xsig[k];
`else
      exp_s = 2'b00;
`endif
      n_chk++;
      if (rsig[k] !== exp_s) begin
        n_fail++;
        $display("FAIL sig_step%0d: got %b expected %b", k, rsig[k], exp_s);
      end
      n_chk++;
      if (r1[k] !== x1[k]) begin
        n_fail++;
        $display("FAIL sig_lane%0d: got %b expected %b", k, r1[k], x1[k]);
      end
    end
`ifdef MIX_PIPE_MISR_EN
    exp_s = 2'b10;
`else
    exp_s = 2'b00;
`endif
    n_chk++;
    if (sig1 !== exp_s || count1 !== 8'd3) begin
      n_fail++;
      $display("FAIL sig_final: got sig %b count %0d expected sig %b count 3",
               sig1, count1, exp_s);
    end
  endtask

  task automatic test_backpressure();
    run_sess(6, 4, 4, -1);
    n_chk++;
    if (stall_bad != 0 || tmo != 0) begin
      n_fail++;
      $display("FAIL bp_stall: got %0d violations tmo %0d expected 0",
               stall_bad, tmo);
    end
    n_chk++;
    if (n_out != 6 || n_hs != 6) begin
      n_fail++;
      $display("FAIL bp_xfers: got out %0d in %0d expected 6 6",
               n_out, n_hs);
    end
    for (int k = 0; k < 6 && k < n_out; k++) begin
      n_chk++;
      if (r16[k] !== x16[k % 3] || r17[k] !== x17[k % 3]) begin
        n_fail++;
        $display("FAIL bp_vec%0d: got %h/%h expected %h/%h",
                 k, r16[k], r17[k], x16[k % 3], x17[k % 3]);
      end
    end
    n_chk++;
    if (count !== 8'd6 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL bp_count: got %0d done %0d expected 6 done 1",
               count, done_cnt);
    end
  endtask

  task automatic test_len_zero();
    run_sess(0, 0, 0, -1);
    n_chk++;
    if (done_cnt != 1 || done_cyc != 1) begin
      n_fail++;
      $display("FAIL len0_done: got cnt %0d cyc %0d expected 1 1",
               done_cnt, done_cyc);
    end
    n_chk++;
    if (ir_seen != 0 || count !== 8'd0 || n_out != 0) begin
      n_fail++;
      $display("FAIL len0_idle: got ready %0d count %0d out %0d expected 0 0 0",
               ir_seen, count, n_out);
    end
    run_sess(2, 0, 0, 2);
    n_chk++;
    if (count !== 8'd2 || n_out != 2 || done_cnt != 1 || tmo != 0) begin
      n_fail++;
      $display("FAIL restart_ign: got count %0d out %0d done %0d expected 2 2 1",
               count, n_out, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      a = va[k]; b = vb[k]; c = vc[k]; d = vd[k]; e = ve[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b1 || out_valid !== 1'b1 || count !== 8'd1) begin
      n_fail++;
      $display("FAIL rst_pre: got busy %b ov %b count %0d expected 1 1 1",
               busy, out_valid, count);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({in_ready, out_valid, busy, done} !== 4'b0000 ||
        {o16, o17, count, sig, sig1} !== 26'h0) begin
      n_fail++;
      $display("FAIL rst_async: got %b %h expected 0000 0",
               {in_ready, out_valid, busy, done},
               {o16, o17, count, sig, sig1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_sess(3, 0, 0, -1);
    n_chk++;
    if (n_out != 3 || count !== 8'd3 || done_cnt != 1 || tmo != 0) begin
      n_fail++;
      $display("FAIL rst_after: got out %0d count %0d done %0d expected 3 3 1",
               n_out, count, done_cnt);
    end
    for (int k = 0; k < 3 && k < n_out; k++) begin
      n_chk++;
      if (r16[k] !== x16[k] || r17[k] !== x17[k]) begin
        n_fail++;
        $display("FAIL rst_vec%0d: got %h/%h expected %h/%h",
                 k, r16[k], r17[k], x16[k], x17[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mixing();
    test_signature();
    test_backpressure();
    test_len_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mix_pipe.md
# mix_pipe

- Parametrised sequential successor to the combinational NAND mixing netlist.
- Applies a LANES-wide six-NAND mixing network to each accepted input vector and carries the results through a DEPTH-stage valid/ready pipeline.
- Groups transfers into length-bounded sessions under a small FSM.
- Optionally compresses every output into a multiple-input signature register (MISR).
- Serves as the team's parametrised sequential benchmark netlist for graph extraction, unrolling and equivalence tests.

## Interface
Parameters:
- LANES, 4, independent bit-lanes in the mixing network (≥1)
- DEPTH, 2, pipeline register stages (≥1)
- CNT_W, 8, width of session length and counters

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin session; sampled only in IDLE
- len  in  CNT_W  transfers in session; sampled with start
- in_valid  in  1  input vector valid
- in_ready  out  1  input vector accepted when both high
- a, b, c, d, e  in  LANES each  per-lane mixing inputs
- out_valid  out  1  o16/o17 valid
- out_ready  in  1  downstream accept
- o16, o17  out  LANES each  per-lane mixed outputs
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at session end
- count  out  CNT_W  outputs retired this session
- sig  out  2*LANES  signature {o17,o16}-compressed

## Operation
Mixing per lane (combinational, ahead of stage 1):
- n8 = ~(a&c)
- n9 = ~(c&d)
- n12 = ~(b&n9)
- n15 = ~(n9&e)
- o16 = ~(n8&n12)
- o17 = ~(n12&n15)

FSM:
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on start with len≠0, go to RUN; issued, count and sig clear. On start with len==0, go to DONE.
- RUN: issued increments on each input handshake. When issued reaches len, go to DRAIN.
- DRAIN: count increments on each output handshake. When count==len, go to DONE. Count also increments during RUN.
- DONE: done=1 for exactly one cycle, then IDLE. sig and count hold until the next start.
- start outside IDLE is ignored.

Handshake and pipeline:
- in_ready = (state==RUN) && (issued<len) && !stall.
- stall = out_valid && !out_ready. A stall freezes every stage; no bubble collapse.
- The pipe advances when !stall. A stage's valid bit loads the prior stage's valid, or the input handshake for stage 1.
- Data is held stable while out_valid && !out_ready.
- Simultaneous input and output handshakes are both honoured in the same cycle.

Counters:
- count and issued wrap is impossible by construction, since both are ≤ len.

Reset:
- rst_n low clears the FSM to IDLE and clears all valid bits, data, counters and sig, regardless of the current state.
- Reset values: in_ready 0, out_valid 0, o16 0, o17 0, busy 0, done 0, count 0, sig 0.

## Timing
- Latency: DEPTH cycles from input handshake to out_valid, with out_ready held high.
- Throughput: one vector per cycle.
- done asserts the cycle after the final output handshake.
- Minimum session length in cycles: len + DEPTH + 2.
- busy rises the cycle after start.

## Configuration
- MIX_PIPE_MISR_EN defined:
  - W = 2*LANES.
  - On each output handshake: sig ← ({sig[W-2:0],1'b0} ^ (sig[W-1] ? MISR_TAPS : 0)) ^ {o17,o16}.
  - sig clears on accepted start.
- MIX_PIPE_MISR_EN undefined:
  - No signature flops.
  - sig tied to 0.
  - All other behaviour is unchanged.

## Structure
- Package mix_pipe_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - function misr_taps(W), returning bits 0..2 set, masked to W
- Sub-module mix_core holds the combinational LANES-wide NAND network only: inputs a..e, outputs o16/o17.
- mix_pipe holds the FSM, pipeline, counters and MISR.

## Test plan
- Mixing values, LANES=4, DEPTH=2, len=3, out_ready=1. Vectors applied in order:
  - all inputs 4'hF: o16=F, o17=0
  - a=F, b=0, c=F, d=0, e=F: o16=F, o17=F
  - all inputs 0: o16=0, o17=0
  - Each output appears 2 cycles after its handshake; done pulses once; count=3.
- Signature, LANES=1, MISR enabled, same three vectors, len=3:
  - sig sequence after each handshake is 01, 01, 10.
  - Final sig=2'b10.
- Backpressure: out_ready low for 4 cycles mid-session.
  - out_valid and o16/o17 stay stable.
  - in_ready=0 throughout the stall.
  - No vector is lost or duplicated; count reaches len.
- len==0: start goes IDLE→DONE.
  - done is high for 1 cycle.
  - in_ready is never asserted; count=0.
  - start pulsed during RUN is ignored.
- Reset mid-session: rst_n low during DRAIN with 2 vectors in flight.
  - All outputs take their reset values immediately, asynchronously.
  - A fresh start after release runs a clean session.
- Build without MIX_PIPE_MISR_EN, repeat the signature scenario:
  - sig=0 throughout.
  - o16, o17, count and done match the enabled build.
